// File: rtl/de_uop_queue.sv
// de_uop_queue
//   Decode-to-AG micro-op queue. It buffers up to DEPTH decoded bundles so
//   that decode keeps running while AG is stalled. Issue is held while the
//   head uop has a register dependency. When SERIALIZE_JMP is set, enqueue
//   is blocked behind a jump uop until jmp_resolve. A flush empties the queue.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   de_v/de_uop/de_jmp  decode bundle in; de_ready is the accept handshake
//   reg_dep             head uop has an unresolved register dependency
//   mem_dep/mr_stall/mw_stall  AG stall sources (combined into ld_ag)
//   flush               synchronous redirect flush
//   jmp_resolve         outstanding jump resolved (one-cycle pulse)
//   ag_vin/ag_uop/ag_jmp  head entry toward AG (zeroed when empty)
//   ld_ag               AG latch load enable
//   count/full/empty    occupancy status
module de_uop_queue #(
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned UOP_W         = 256,
   parameter int unsigned SERIALIZE_JMP = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       de_v,
   input  logic [UOP_W-1:0]           de_uop,
   input  logic [2:0]                 de_jmp,
   output logic                       de_ready,
   input  logic                       reg_dep,
   input  logic                       mem_dep,
   input  logic                       mr_stall,
   input  logic                       mw_stall,
   input  logic                       flush,
   input  logic                       jmp_resolve,
   output logic                       ag_vin,
   output logic [UOP_W-1:0]           ag_uop,
   output logic [2:0]                 ag_jmp,
   output logic                       ld_ag,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   typedef enum logic {RUN, WAIT_JMP} state_e;

   state_e                  state_q, state_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [UOP_W-1:0]        uop_mem_q [DEPTH];
   logic [2:0]              jmp_mem_q [DEPTH];

   logic stall;
   logic push;
   logic pop;

   assign stall    = mem_dep | mr_stall | mw_stall;
   assign ld_ag    = !stall;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

   assign ag_vin   = !empty && !reg_dep && !flush;
   assign ag_uop   = empty ? '0 : uop_mem_q[rd_ptr_q];
   assign ag_jmp   = empty ? '0 : jmp_mem_q[rd_ptr_q];

   // No full pass-through: a full queue refuses even when it pops this cycle.
   assign de_ready = !full && (state_q == RUN) && !flush;

   assign push     = de_v && de_ready;
   assign pop      = ag_vin && ld_ag;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         state_d  = RUN;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
         if (SERIALIZE_JMP != 0) begin
            // A jump push takes priority over a coincident resolve.
            if (push && (de_jmp != 3'd0))
               state_d = WAIT_JMP;
            else if ((state_q == WAIT_JMP) && jmp_resolve)
               state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= RUN;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
      end
   end

   // Storage is not reset; outputs are masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         uop_mem_q[wr_ptr_q] <= de_uop;
         jmp_mem_q[wr_ptr_q] <= de_jmp;
      end
   end

endmodule

// File: doc/de_uop_queue.md
Name: de_uop_queue

Overview:
- Parametrised decode-to-address-generation micro-op queue. It replaces the single-entry DE output latch.
- Buffers up to DEPTH decoded uop bundles so that decode keeps running while AG is stalled by memory dependencies or read/write stalls.
- Holds issue while a register dependency is outstanding.
- Optionally serialises decode behind control-transfer uops until they are resolved; a flush clears the queue on redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, at least 2.
- UOP_W, 256, width of the packed decoded bundle (re/we/rmsel/alusel/dval/sval/disp/flags/sreg/ptr/modrm fields, packed by DE).
- SERIALIZE_JMP, 1, when 1, an enqueued uop with nonzero jmp field blocks further enqueue until jmp_resolve.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- de_v  in  1  decode bundle valid.
- de_uop  in  UOP_W  decoded bundle.
- de_jmp  in  3  jump type of the bundle; 0 means not a jump.
- de_ready  out  1  queue accepts the bundle this cycle.
- reg_dep  in  1  head uop has an unresolved register dependency.
- mem_dep  in  1  AG stall: memory dependency.
- mr_stall  in  1  AG stall: memory read.
- mw_stall  in  1  AG stall: memory write.
- flush  in  1  synchronous redirect flush.
- jmp_resolve  in  1  one-cycle pulse: outstanding jump resolved.
- ag_vin  out  1  head uop valid toward AG.
- ag_uop  out  UOP_W  head bundle.
- ag_jmp  out  3  head jump type.
- ld_ag  out  1  AG latch load enable.
- count  out  clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rd_ptr, wr_ptr and count are 0; state is RUN.
  - Outputs during reset: de_ready=1, ag_vin=0, ag_uop=0, ag_jmp=0, full=0, empty=1.
  - ld_ag follows its combinational equation below, even during reset.
  - Storage contents do not matter, because the outputs are masked when the queue is empty.
- Reset asserted mid-operation: all contents are discarded immediately.
- Stall: stall = mem_dep | mr_stall | mw_stall, and ld_ag = !stall (combinational).
- Issue side (combinational from registered state plus reg_dep and flush):
  - ag_vin = !empty & !reg_dep & !flush.
  - ag_uop and ag_jmp are the head entry contents, forced to 0 when empty.
- Pop: occurs on a rising edge when ag_vin & ld_ag; rd_ptr advances by 1 modulo DEPTH.
- Accept condition: de_ready = !full & (state==RUN) & !flush.
- Push:
  - Occurs when de_v & de_ready; the bundle and jmp are written at wr_ptr, and wr_ptr advances modulo DEPTH.
  - Push-to-head latency is 1 cycle: a uop pushed into an empty queue appears at ag_uop on the next cycle. There is no same-cycle bypass.
- Push and pop in the same cycle: count is unchanged.
- Full queue: de_ready=0 even if a pop occurs that cycle (no full-pass-through).
- Empty queue: no pop; ag_vin=0 regardless of reg_dep and stall.
- count is updated as +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH or goes below 0.
- State machine (only when SERIALIZE_JMP=1; otherwise the state stays RUN):
  - RUN -> WAIT_JMP on a push with de_jmp != 0.
  - WAIT_JMP -> RUN on jmp_resolve.
  - In WAIT_JMP, de_ready=0; already-queued uops, including the jump, continue to issue.
  - jmp_resolve in RUN is ignored.
  - jmp_resolve in the same cycle as a jump push: the push wins, and the state goes to WAIT_JMP.
- Flush (synchronous):
  - On a rising edge with flush=1: pointers and count go to 0 and state goes to RUN.
  - Any push or pop that cycle is suppressed, which follows because de_ready and ag_vin are both 0.
  - flush overrides jmp_resolve.
- full = (count==DEPTH), empty = (count==0), both from registered count.
- Pointer wrap: pointers are clog2(DEPTH) bits; the full/empty distinction comes from count, not from pointer comparison.

Test Plan:
1. DEPTH=4, reset released, push uops A=0x1, B=0x2 on consecutive cycles with no stalls and reg_dep=0 -> A appears at ag_uop the cycle after its push with ag_vin=1 and ld_ag=1; B appears next; count returns to 0 and empty=1.
2. Hold mr_stall=1 and push 5 uops back-to-back -> count 1,2,3,4; full=1 and de_ready=0 on the 5th; ag_uop stays at the first uop. Release the stall -> pops in order; the 5th is accepted once count is 3, the cycle after the first pop.
3. Queue holds 2 uops, reg_dep=1 for 3 cycles -> ag_vin=0 and count stays 2. Drop reg_dep -> ag_vin=1 and the head pops. Simultaneous push and pop -> count unchanged.
4. SERIALIZE_JMP=1: push uop with de_jmp=3'b010, then hold de_v=1 -> de_ready=0 from the next cycle; the jump uop still issues with ag_jmp=2. Pulse jmp_resolve -> de_ready=1 next cycle.
5. Queue holds 3 uops in WAIT_JMP; assert flush with de_v=1 -> next cycle count=0, empty=1, state RUN, the pushed uop is dropped, and ag_vin=0 during the flush cycle.
6. Fill to 3 entries, then assert rst_n=0 mid-cycle -> ag_vin=0, count=0 and empty=1 immediately, without waiting for a clock edge. Run 12 push/pop pairs after release -> data order is preserved across pointer wrap.
